text_char_fetch: RTL

TEXT_CHAR_FETCH -- requirements
Module: text_char_fetch

---
 rtl/text_pkg.sv | 29 ++
 rtl/sideband_delay.sv | 25 ++
 rtl/text_char_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants and helpers for the text-mode character fetch pipeline.
package text_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int LATENCY   = 4;
  localparam int TEXT_AW   = 12;
  localparam int FONT_AW   = 12;
  localparam int BLINK_BIT = 5;

  // Text RAM word layout: attribute in the upper byte, character code below.
  localparam int ATTR_MSB = 15;
  localparam int ATTR_LSB = 8;
  localparam int CHAR_MSB = 7;
  localparam int CHAR_LSB = 0;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
  } attr_t;

  function automatic logic [TEXT_AW-1:0] cell_addr(input logic [6:0] col,
                                                    input logic [5:0] row);
    return ({6'd0, row} * TEXT_AW'(COLS)) + {5'd0, col};
  endfunction

endpackage

// File: rtl/sideband_delay.sv
// Fixed-depth shift register with synchronous reset for pipeline sideband signals.
module sideband_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/text_char_fetch.sv
// Four-stage text-mode fetch: cell address -> text RAM -> font ROM -> glyph line
// plus colour attribute, with blinking underline cursor and aligned syncs.
module text_char_fetch
  import text_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_de,
  input  logic               in_hs,
  input  logic               in_vs,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [15:0]        text_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  input  logic               cursor_en,
  output logic               out_de,
  output logic               out_hs,
  output logic               out_vs,
  output logic [7:0]         font_line_data,
  output logic [2:0]         char_pix_x,
  output logic [7:0]         bg_fg_index
);

  localparam logic [6:0] COL_LIM = 7'(COLS);
  localparam logic [5:0] ROW_LIM = 6'(ROWS);

  logic [6:0] col;
  logic [5:0] row;
  logic [3:0] glyph;
  logic       eff_de;

  assign col    = pix_x[9:3];
  assign row    = pix_y[9:4];
  assign glyph  = pix_y[3:0];
  assign eff_de = in_de && (col < COL_LIM) && (row < ROW_LIM);

  logic [6:0] sync_d4;
  logic       de_d4, hs_d4, vs_d4, eff_d4;
  logic [2:0] px_d4;

  sideband_delay #(.WIDTH(7), .DEPTH(LATENCY)) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({in_de, in_hs, in_vs, eff_de, pix_x[2:0]}),
    .dout (sync_d4)
  );

  assign {de_d4, hs_d4, vs_d4, eff_d4, px_d4} = sync_d4;

  // The live bit keeps the font stage from consuming a RAM word read before reset.
  logic [17:0] cell_d2;
  logic        live_d2;
  logic [3:0]  glyph_d2;
  logic [6:0]  col_d2;
  logic [5:0]  row_d2;

  sideband_delay #(.WIDTH(18), .DEPTH(LATENCY/2)) u_cell_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({1'b1, glyph, col, row}),
    .dout (cell_d2)
  );

  assign {live_d2, glyph_d2, col_d2, row_d2} = cell_d2;

  logic [5:0] frame_cnt;
  logic       vs_prev;
  logic       cursor_hit;
  attr_t      attr_raw;
  logic [7:0] attr_q;
  logic [7:0] attr_q2;

  assign attr_raw   = attr_t'(text_data[ATTR_MSB:ATTR_LSB]);
  assign cursor_hit = cursor_en && (col_d2 == cursor_col) &&
                      (row_d2 == {1'b0, cursor_row}) && (glyph_d2 >= 4'd14) &&
                      !frame_cnt[BLINK_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      text_addr      <= '0;
      font_addr      <= '0;
      attr_q         <= '0;
      attr_q2        <= '0;
      frame_cnt      <= '0;
      vs_prev        <= 1'b0;
      out_de         <= 1'b0;
      out_hs         <= 1'b0;
      out_vs         <= 1'b0;
      font_line_data <= '0;
      char_pix_x     <= '0;
      bg_fg_index    <= '0;
    end else begin
      text_addr <= eff_de ? cell_addr(col, row) : '0;

      vs_prev <= in_vs;
      if (in_vs && !vs_prev) frame_cnt <= frame_cnt + 6'd1;

      if (live_d2) begin
        font_addr <= {text_data[CHAR_MSB:CHAR_LSB], glyph_d2};
        attr_q    <= cursor_hit ? {attr_raw.fg, attr_raw.bg} : attr_raw;
      end else begin
        font_addr <= '0;
        attr_q    <= '0;
      end
      attr_q2 <= attr_q;

      // Blank cells beyond the text area are forced to zero for the colour stage.
      out_de         <= de_d4 && eff_d4;
      out_hs         <= hs_d4;
      out_vs         <= vs_d4;
      font_line_data <= eff_d4 ? font_data : '0;
      bg_fg_index    <= eff_d4 ? attr_q2   : '0;
      char_pix_x     <= eff_d4 ? px_d4     : '0;
    end
  end

endmodule
